// File: rtl/rf_wr_arb.sv
// rf_wr_arb: round-robin arbiter of two writeback requesters onto one register-file write port (RF_ARB_FWD_EN enables write-to-read forwarding)
module rf_wr_arb #(
  parameter int M = 32,
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [N-1:0] req0_addr,
  input  logic [M-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [N-1:0] req1_addr,
  input  logic [M-1:0] req1_data,
  output logic         req1_ready,
  output logic         we_fr,
  output logic [N-1:0] wa_fr,
  output logic [M-1:0] wd_fr,
  input  logic [N-1:0] ra1,
  input  logic [N-1:0] ra2,
  input  logic [M-1:0] rd1_rf,
  input  logic [M-1:0] rd2_rf,
  output logic [M-1:0] rd1,
  output logic [M-1:0] rd2,
  output logic [15:0]  conf_cnt
);
  logic         last_grant;
  logic         xfer;
  logic [N-1:0] w_addr;
  logic [M-1:0] w_data;
  // sole valid requester wins; on a tie the one not granted last wins (last_grant=1 means requester 1)
  always_comb begin
    req0_ready = !rst && req0_valid && (!req1_valid || last_grant);
    req1_ready = !rst && req1_valid && (!req0_valid || !last_grant);
    xfer       = req0_ready || req1_ready;
    w_addr     = req1_ready ? req1_addr : req0_addr;
    w_data     = req1_ready ? req1_data : req0_data;
  end
  // write stage and round-robin history; address 0 is consumed without enabling the write
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_fr      <= 1'b0;
      wa_fr      <= '0;
      wd_fr      <= '0;
      last_grant <= 1'b1;
    end else begin
      we_fr <= xfer && (w_addr != '0);
      if (xfer) begin
        wa_fr      <= w_addr;
        wd_fr      <= w_data;
        last_grant <= req1_ready;
      end
    end
  // saturating count of cycles where both requesters contend
  always_ff @(posedge clk or posedge rst)
    if (rst) conf_cnt <= '0;
    else if (req0_valid && req1_valid && conf_cnt != 16'hFFFF) conf_cnt <= conf_cnt + 16'd1;
  // read path: register 0 always reads as zero, optionally bypassing the pending write
  always_comb begin
`ifdef RF_ARB_FWD_EN
    rd1 = (ra1 == '0) ? '0 : (we_fr && wa_fr == ra1) ? wd_fr : rd1_rf;
    rd2 = (ra2 == '0) ? '0 : (we_fr && wa_fr == ra2) ? wd_fr : rd2_rf;
`else
    rd1 = (ra1 == '0) ? '0 : rd1_rf;
    rd2 = (ra2 == '0) ? '0 : rd2_rf;
`endif
  end
endmodule
